// File: rtl/alu_seq_ctrl.sv
// Nibble-serial 16-bit ALU sequencer around one external 74181-style slice.
// Optional eq accumulation: define ALU_SEQ_EQ_EN.
module alu_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  input  logic [3:0]  op_s,
  input  logic        op_m,
  input  logic        op_cn,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        cout,
  output logic        eq,
  output logic [3:0]  slice_a,
  output logic [3:0]  slice_b,
  output logic [3:0]  slice_s,
  output logic        slice_m,
  output logic        slice_cn,
  input  logic [3:0]  slice_f,
  input  logic        slice_cout,
  input  logic        slice_eq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [1:0]  idx;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [3:0]  s_q;
  logic        m_q;
  logic        cn_q;
  logic        carry_q;

  // Sequencer: latch operands, step through nibbles, pulse done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= 2'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= 16'd0;
      cout    <= 1'b0;
      a_q     <= 16'd0;
      b_q     <= 16'd0;
      s_q     <= 4'd0;
      m_q     <= 1'b0;
      cn_q    <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_q   <= op_a;
            b_q   <= op_b;
            s_q   <= op_s;
            m_q   <= op_m;
            cn_q  <= op_cn;
            idx   <= 2'd0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          result[{idx, 2'b00} +: 4] <= slice_f;
          carry_q <= slice_cout;
          idx     <= idx + 2'd1;
          if (idx == 2'd3) begin
            cout  <= slice_cout;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Slice drive: current nibble in RUN, quiet zeros otherwise.
  always_comb begin
    slice_a  = 4'd0;
    slice_b  = 4'd0;
    slice_s  = 4'd0;
    slice_m  = 1'b0;
    slice_cn = 1'b0;
    if (state == RUN) begin
      slice_a  = a_q[{idx, 2'b00} +: 4];
      slice_b  = b_q[{idx, 2'b00} +: 4];
      slice_s  = s_q;
      slice_m  = m_q;
      slice_cn = (idx == 2'd0) ? cn_q : carry_q;
    end
  end

`ifdef ALU_SEQ_EQ_EN
  logic eq_q;

  // Word equality: AND of per-nibble A=B, restarted on nibble 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      eq_q <= 1'b0;
    end else if (state == RUN) begin
      eq_q <= (idx == 2'd0) ? slice_eq : (eq_q & slice_eq);
    end
  end

  assign eq = eq_q;
`else
  logic eq_unused;
  assign eq_unused = slice_eq;
  assign eq = 1'b0;
`endif

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have ports: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: start  in  1  request one 16-bit operation.
REQ-004 SHALL have ports: op_a / op_b  in  16 each  operands.
REQ-005 SHALL have ports: op_s  in  4, op_m  in  1, op_cn  in  1  select, mode, carry-in for the whole word.
REQ-006 SHALL have ports: busy  out  1, done  out  1, result  out  16, cout  out  1, eq  out  1.
REQ-007 SHALL have ports: slice_a / slice_b  out  4, slice_s  out  4, slice_m  out  1, slice_cn  out  1  drive to one external 74181-style 4-bit slice.
REQ-008 SHALL have ports: slice_f  in  4, slice_cout  in  1, slice_eq  in  1  combinational return from that slice.

Function
REQ-009 SHALL implement FSM states IDLE, RUN, DONE with a 2-bit nibble index idx.
REQ-010 SHALL accept start only in IDLE; latch op_a, op_b, op_s, op_m, op_cn; go RUN with idx=0.
REQ-011 SHALL ignore start in RUN and DONE; operand input changes after acceptance SHALL NOT affect the operation.
REQ-012 SHALL in RUN drive slice_a/slice_b = latched nibble idx, slice_s/slice_m = latched op_s/op_m.
REQ-013 SHALL drive slice_cn = latched op_cn when idx=0, else registered slice_cout from the previous nibble (raw polarity, no inversion).
REQ-014 SHALL in each RUN cycle capture slice_f into result[4*idx+3:4*idx], register slice_cout, then increment idx.
REQ-015 SHALL go RUN->DONE on the edge capturing idx=3; cout = slice_cout of nibble 3.
REQ-016 SHALL hold done high for exactly one cycle in DONE, then return to IDLE.
REQ-017 SHALL have latency: edge sampling start = E0; nibbles captured on E1..E4; done high between E4 and E5.
REQ-018 SHALL have busy high exactly in RUN; busy and done never high together.
REQ-019 SHALL hold result, cout, eq stable from DONE until the next accepted start.
REQ-020 SHALL drive all slice_* outputs to 0 in IDLE and DONE.
REQ-021 SHALL accept start asserted in the cycle immediately after done (back-to-back ops, 6-cycle period).

Reset
REQ-022 SHALL on rst at any edge enter IDLE, idx=0, busy=0, done=0, result=0, cout=0, eq=0, slice_* = 0.
REQ-023 SHALL on rst during RUN abort the operation without a done pulse; rst has priority over start in the same cycle.

Configuration
REQ-024 SHALL support macro ALU_SEQ_EQ_EN.
REQ-025 SHALL with ALU_SEQ_EQ_EN defined accumulate eq = AND of slice_eq over nibbles 0..3, updated with result.
REQ-026 SHALL without ALU_SEQ_EQ_EN keep the eq port present, tied to 0, with no accumulation logic.

Verification
REQ-027 SHALL verify: op_a=0x1234, op_b=0x0FFF, S=1001, M=0, Cn=1 -> result=0x2233, cout=1, done 4 cycles after start, busy high 4 cycles.
REQ-028 SHALL verify: op_a=0xFFFF, op_b=0x0001, S=1001, M=0, Cn=1 -> result=0x0000, cout=0 (ripple through all nibbles).
REQ-029 SHALL verify: op_a=0xF0F0, op_b=0xFF00, S=0110, M=1 -> result=0x0FF0; slice_m=1 in all RUN cycles.
REQ-030 SHALL verify: op_a=op_b=0x5A5A, S=0110, M=0, Cn=1 -> result=0xFFFF; eq=1 with ALU_SEQ_EQ_EN, eq=0 without.
REQ-031 SHALL verify: start held high continuously plus operand changes mid-RUN -> one op per 6 cycles, results from latched operands only.
REQ-032 SHALL verify: rst asserted at idx=2 -> next cycle all outputs 0, state IDLE, no done pulse; a fresh start then completes normally.
